// File: rtl/alu_operand_seq.sv
// Operand sequencer for a shared-bus ALU: loads two operands, drives one
// execute cycle, then reads back the result and flags.
module alu_operand_seq #(
  parameter int              DATA_W = 8,
  parameter int              OP_W   = 5,
  parameter logic [OP_W-1:0] OP_NOP = '0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_data_valid,
  input  logic              i_abort,
  input  logic [DATA_W-1:0] i_result,
  input  logic [3:0]        i_nzcv,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_bus_a,
  output logic [DATA_W-1:0] o_bus_b,
  output logic              o_bus_en,
  output logic [OP_W-1:0]   o_alu_op,
  output logic              o_alu_read,
  output logic [DATA_W-1:0] o_result,
  output logic [3:0]        o_nzcv,
  output logic              o_done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    EXEC,
    CAPTURE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [OP_W-1:0] op_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Abort wins over a coincident operand; once in EXEC the operation is committed.
  always_comb begin
    // NOTE: defaulting before the case keeps this block free of inferred latches.
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = LOAD_A;
      LOAD_A: begin
        if (i_abort)           state_nxt = IDLE;
        else if (i_data_valid) state_nxt = LOAD_B;
      end
      LOAD_B: begin
        if (i_abort)           state_nxt = IDLE;
        else if (i_data_valid) state_nxt = EXEC;
      end
      EXEC:    state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready    = 1'b0;
    o_bus_en   = 1'b0;
    o_alu_op   = OP_NOP;
    o_alu_read = 1'b0;
    case (state)
      IDLE:    o_ready = 1'b1;
      EXEC: begin
        o_bus_en = 1'b1;
        o_alu_op = op_q;
      end
      CAPTURE: o_alu_read = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      op_q     <= OP_NOP;
      o_bus_a  <= '0;
      o_bus_b  <= '0;
      o_result <= '0;
      o_nzcv   <= 4'b0000;
      o_done   <= 1'b0;
    end else begin
      o_done <= (state == CAPTURE);
      case (state)
        IDLE:    if (i_start) op_q <= i_op;
        LOAD_A:  if (!i_abort && i_data_valid) o_bus_a <= i_data;
        LOAD_B:  if (!i_abort && i_data_valid) o_bus_b <= i_data;
        CAPTURE: begin
          o_result <= i_result;
          o_nzcv   <= i_nzcv;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_operand_seq.sv
// Self-checking bench for alu_operand_seq: directed scenarios followed by
// randomized traffic, all compared against a transaction-level model.
module tb_alu_operand_seq;

  localparam logic [4:0] NOP = 5'b00000;
  localparam logic [4:0] SUM = 5'b00001;
  localparam logic [4:0] SUB = 5'b00010;
  localparam logic [4:0] XOR = 5'b00011;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] op;
  logic [7:0] data;
  logic       valid;
  logic       abort;
  logic [7:0] alu_res;
  logic [3:0] alu_nzcv;

  logic       o_ready;
  logic [7:0] o_bus_a;
  logic [7:0] o_bus_b;
  logic       o_bus_en;
  logic [4:0] o_alu_op;
  logic       o_alu_read;
  logic [7:0] o_result;
  logic [3:0] o_nzcv;
  logic       o_done;

  alu_operand_seq dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_op         (op),
    .i_data       (data),
    .i_data_valid (valid),
    .i_abort      (abort),
    .i_result     (alu_res),
    .i_nzcv       (alu_nzcv),
    .o_ready      (o_ready),
    .o_bus_a      (o_bus_a),
    .o_bus_b      (o_bus_b),
    .o_bus_en     (o_bus_en),
    .o_alu_op     (o_alu_op),
    .o_alu_read   (o_alu_read),
    .o_result     (o_result),
    .o_nzcv       (o_nzcv),
    .o_done       (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Returns {N,Z,C,V,result}.
  function automatic logic [11:0] alu_f(input logic [4:0] f, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] r;
    logic       c;
    logic       v;
    c = 1'b0;
    v = 1'b0;
    if (f == SUM) begin
      r = {1'b0, a} + {1'b0, b};
      c = r[8];
      v = (a[7] == b[7]) && (r[7] != a[7]);
    end else if (f == SUB) begin
      r = {1'b0, a} - {1'b0, b};
      c = r[8];
      v = (a[7] != b[7]) && (r[7] != a[7]);
    end else begin
      r = {1'b0, a ^ b};
    end
    return {r[7], (r[7:0] == 8'h00), c, v, r[7:0]};
  endfunction

  // ALU evaluates on the falling edge while the sequencer drives the bus.
  initial begin
    alu_res  = '0;
    alu_nzcv = '0;
  end
  always @(negedge clk) if (o_bus_en) {alu_nzcv, alu_res} = alu_f(o_alu_op, o_bus_a, o_bus_b);

  int checks = 0;
  int passes = 0;
  int ncyc   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Transaction model: an operation is active, has collected 0..2 operands,
  // and after the second operand spends one drive cycle then one read cycle.
  bit         m_active;
  int         m_nops;
  int         m_cnt;
  logic [4:0] m_op;
  logic [7:0] m_a, m_b, m_res;
  logic [3:0] m_nzcv;
  bit         m_done;

  task automatic cyc();
    bit d;
    bit drive;
    d = 1'b0;
    if (rst) begin
      m_active = 0; m_nops = 0; m_cnt = 0; m_op = NOP;
      m_a = '0; m_b = '0; m_res = '0; m_nzcv = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_nops = 0; m_cnt = 0; m_op = op;
      end
    end else if (m_nops < 2) begin
      if (abort) m_active = 0;
      else if (valid) begin
        if (m_nops == 0) m_a = data;
        else             m_b = data;
        m_nops++;
      end
    end else if (m_cnt == 0) begin
      m_cnt = 1;
    end else begin
      {m_nzcv, m_res} = alu_f(m_op, m_a, m_b);
      m_active = 0;
      d = 1'b1;
    end
    m_done = d;

    @(posedge clk);
    #1;
    ncyc++;
    drive = m_active && (m_nops == 2) && (m_cnt == 0);
    check("ready",    16'(o_ready),    16'(!m_active));
    check("bus_en",   16'(o_bus_en),   16'(drive));
    check("alu_op",   16'(o_alu_op),   16'(drive ? m_op : NOP));
    check("alu_read", 16'(o_alu_read), 16'(m_active && (m_nops == 2) && (m_cnt == 1)));
    check("bus_a",    16'(o_bus_a),    16'(m_a));
    check("bus_b",    16'(o_bus_b),    16'(m_b));
    check("result",   16'(o_result),   16'(m_res));
    check("nzcv",     16'(o_nzcv),     16'(m_nzcv));
    check("done",     16'(o_done),     16'(m_done));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int en_cnt;
    int start_cyc;
    bit overlap;

    rst = 1'b1; start = 1'b0; op = NOP; data = '0; valid = 1'b0; abort = 1'b0;
    m_active = 0; m_nops = 0; m_cnt = 0; m_op = NOP;
    m_a = '0; m_b = '0; m_res = '0; m_nzcv = '0; m_done = 0;
    cyc();
    cyc();
    rst = 1'b0;
    check("rst_ready", 16'(o_ready), 16'd1);
    check("rst_result", 16'(o_result), 16'h0);

    // Nominal SUM 0x12 + 0x34
    start = 1'b1; op = SUM; cyc();
    start = 1'b0; valid = 1'b1; data = 8'h12; cyc();
    data = 8'h34; cyc();
    valid = 1'b0; cyc();
    cyc();
    check("nom_done",   16'(o_done),   16'd1);
    check("nom_result", 16'(o_result), 16'h46);
    check("nom_nzcv",   16'(o_nzcv),   16'h0);
    cyc();
    check("nom_done_pulse", 16'(o_done), 16'd0);

    // Stalled operands: 3-cycle gap before A, 2-cycle gap before B
    start_cyc = ncyc;
    start = 1'b1; op = SUB; cyc();
    start = 1'b0;
    repeat (3) cyc();
    valid = 1'b1; data = 8'h90; cyc();
    valid = 1'b0;
    repeat (2) cyc();
    valid = 1'b1; data = 8'h20; cyc();
    valid = 1'b0;
    en_cnt = int'(o_bus_en);
    for (int i = 0; i < 4 && !o_done; i++) begin
      cyc();
      en_cnt += int'(o_bus_en);
    end
    check("stall_done",    16'(o_done), 16'd1);
    check("stall_latency", 16'(ncyc - start_cyc), 16'd10);
    check("stall_en_cnt",  16'(en_cnt), 16'd1);
    check("stall_result",  16'(o_result), 16'h70);
    cyc();

    // Abort coincident with operand B
    start = 1'b1; op = SUM; cyc();
    start = 1'b0; valid = 1'b1; data = 8'hFF; cyc();
    abort = 1'b1; data = 8'h77; cyc();
    abort = 1'b0; valid = 1'b0;
    check("abort_ready",  16'(o_ready),  16'd1);
    check("abort_result", 16'(o_result), 16'h70);
    cyc();
    check("abort_no_done", 16'(o_done), 16'd0);

    // Ignored inputs: valid with start in IDLE, start in LOAD_B
    start = 1'b1; op = SUM; valid = 1'b1; data = 8'h55; cyc();
    start = 1'b0; data = 8'h10; cyc();
    valid = 1'b0; start = 1'b1; op = SUB; cyc();
    start = 1'b0; valid = 1'b1; data = 8'h03; cyc();
    valid = 1'b0; cyc();
    cyc();
    check("ign_bus_a",  16'(o_bus_a),  16'h10);
    check("ign_result", 16'(o_result), 16'h13);
    cyc();

    // Reset while in EXEC, then a fresh operation
    start = 1'b1; op = SUB; cyc();
    start = 1'b0; valid = 1'b1; data = 8'h50; cyc();
    data = 8'h20; cyc();
    valid = 1'b0;
    check("rexec_in_exec", 16'(o_bus_en), 16'd1);
    rst = 1'b1; cyc();
    rst = 1'b0;
    check("rexec_bus_en", 16'(o_bus_en), 16'd0);
    check("rexec_bus_a",  16'(o_bus_a),  16'h0);
    cyc();
    check("rexec_no_done", 16'(o_done), 16'd0);
    start = 1'b1; op = SUB; cyc();
    start = 1'b0; valid = 1'b1; data = 8'h50; cyc();
    data = 8'h20; cyc();
    valid = 1'b0; cyc();
    cyc();
    check("rexec_result", 16'(o_result), 16'h30);

    // Back-to-back: next start in the done cycle
    cyc();
    overlap = 1'b0;
    start = 1'b1; op = XOR; cyc();
    start = 1'b0; valid = 1'b1; data = 8'hF0; cyc();
    data = 8'h0F; cyc();
    valid = 1'b0;
    repeat (2) begin cyc(); overlap |= o_bus_en & o_alu_read; end
    check("b2b_first_done", 16'(o_done), 16'd1);
    check("b2b_first_nzcv", 16'(o_nzcv), 16'h8);
    start = 1'b1; op = SUM; cyc();
    start = 1'b0; valid = 1'b1; data = 8'h01; cyc();
    data = 8'h02; cyc();
    valid = 1'b0;
    repeat (2) begin cyc(); overlap |= o_bus_en & o_alu_read; end
    check("b2b_second_done",   16'(o_done),   16'd1);
    check("b2b_second_result", 16'(o_result), 16'h03);
    check("b2b_no_overlap",    16'(overlap),  16'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 3) == 0);
      op    = 5'($urandom_range(0, 3));
      data  = 8'($urandom);
      valid = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 15) == 0);
      cyc();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_seq.md
ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

Interface
REQ-001 Parameter DATA_W, default 8: operand and result width in bits.
REQ-002 Parameter OP_W, default 5: ALU opcode width in bits.
REQ-003 Parameter OP_NOP, default 5'b00000: opcode meaning "no operation" to the ALU.
REQ-004 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset, sampled on the rising edge of i_clk.
REQ-006 i_start  input  1  request a new operation; accepted only while o_ready=1.
REQ-007 i_op  input  OP_W  opcode, captured in the same cycle i_start is accepted.
REQ-008 i_data  input  DATA_W  operand byte from the data source.
REQ-009 i_data_valid  input  1  i_data holds a valid operand this cycle.
REQ-010 i_abort  input  1  cancel the pending operation during operand load.
REQ-011 i_result  input  DATA_W  ALU result, read back from the ALU low bus byte.
REQ-012 i_nzcv  input  4  ALU flags {N,Z,C,V}.
REQ-013 o_ready  output  1  sequencer is idle and accepts i_start.
REQ-014 o_bus_a  output  DATA_W  first operand, drives ALU bus bits [15:8].
REQ-015 o_bus_b  output  DATA_W  second operand, drives ALU bus bits [7:0].
REQ-016 o_bus_en  output  1  operand drive enable on the shared bus.
REQ-017 o_alu_op  output  OP_W  opcode presented to the ALU.
REQ-018 o_alu_read  output  1  ALU data and flag read enable.
REQ-019 o_result  output  DATA_W  last captured result.
REQ-020 o_nzcv  output  4  last captured flags.
REQ-021 o_done  output  1  single-cycle pulse: o_result and o_nzcv are updated.

Function
REQ-022 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, EXEC and CAPTURE, all registered.
REQ-023 IDLE: o_ready=1; a rising edge with i_start=1 SHALL capture i_op and move to LOAD_A; i_data_valid is ignored in IDLE, including when it coincides with i_start.
REQ-024 LOAD_A: a rising edge with i_data_valid=1 SHALL latch i_data into o_bus_a and move to LOAD_B; with i_data_valid=0 the FSM waits indefinitely.
REQ-025 LOAD_B: a rising edge with i_data_valid=1 SHALL latch i_data into o_bus_b and move to EXEC.
REQ-026 EXEC: lasts exactly 1 cycle; o_bus_en=1, o_alu_op=captured opcode, o_alu_read=0; the ALU evaluates on the falling edge inside this cycle.
REQ-027 CAPTURE: lasts exactly 1 cycle; o_bus_en=0, o_alu_op=OP_NOP, o_alu_read=1; the rising edge at the end of CAPTURE SHALL register i_result into o_result and i_nzcv into o_nzcv, and move to IDLE.
REQ-028 o_done SHALL be 1 only in the first IDLE cycle after CAPTURE; an i_start accepted in that cycle SHALL be legal.
REQ-029 In every state other than EXEC, o_bus_en SHALL be 0 and o_alu_op SHALL be OP_NOP; o_alu_read SHALL be 1 only in CAPTURE.
REQ-030 Latency: with back-to-back i_data_valid, i_start is sampled at edge 0 and o_done=1 in the cycle following edge 4 (5 cycles).
REQ-031 i_start SHALL be ignored outside IDLE and SHALL NOT alter the captured opcode.
REQ-032 i_abort=1 in LOAD_A or LOAD_B SHALL return the FSM to IDLE on that edge, with no o_done pulse and o_result/o_nzcv unchanged; i_abort SHALL take priority over a simultaneous i_data_valid.
REQ-033 i_abort SHALL be ignored in IDLE, EXEC and CAPTURE, because the operation is committed once it reaches EXEC.
REQ-034 o_bus_a and o_bus_b SHALL hold their values until they are overwritten by the next operand load.

Reset
REQ-035 Priority SHALL be i_reset > i_abort > all other inputs.
REQ-036 i_reset=1 SHALL, at the rising edge, force: state IDLE; o_bus_a=0; o_bus_b=0; o_result=0; o_nzcv=4'b0000; o_done=0; o_bus_en=0; o_alu_read=0; o_alu_op=OP_NOP; captured opcode=OP_NOP.
REQ-037 A reset asserted in any state, including mid-EXEC, SHALL discard the operation with no o_done pulse.

Verification
REQ-038 Nominal: start with op=SUM, data 0x12 then 0x34 on consecutive cycles, ALU model returns 0x46/nzcv=0000 -> o_done at cycle 5, o_result=0x46, o_nzcv=0000.
REQ-039 Stalled operands: data_valid gaps of 3 cycles before A and 2 cycles before B -> o_done at cycle 10, and o_bus_en high for exactly 1 cycle.
REQ-040 Abort: start, A=0xFF, then abort coincident with data_valid for B -> IDLE next cycle, no o_done, o_result keeps its previous value.
REQ-041 Ignored inputs: data_valid together with start in IDLE, and start asserted in LOAD_B with op=SUB -> the first post-start operand is A, and the original opcode is used.
REQ-042 Reset during EXEC -> all outputs at reset values the next cycle, no o_done; a fresh operation afterwards completes normally.
REQ-043 Back-to-back: start asserted in the o_done cycle -> the second operation is accepted, o_done 5 cycles later, and no cycle has o_bus_en=1 together with o_alu_read=1.
